adder_sweep_checker: RTL and testbench
======================================

Name: adder_sweep_checker

Overview:
- Drives the other end of the nibble-adder interface: it generates operand bytes ({a,b}, 4 bits each) and checks the returned sum.
- Sweeps all 256 operand pairs, then reports the error count, the first failing pair and a pass flag.
- Sits on the stimulus side of the adder pins (op_out feeds the adder's ui_in; the adder's uo_out feeds sum_in). Used for on-chip self-test and for bench loopback.

Parameters:
- LATENCY, 1, clock edges from op_out change until sum_in reflects it; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a sweep when the block is idle or done
- op_out  output  8  registered operand byte: [7:4]=a, [3:0]=b
- sum_in  input  8  adder result; [3:0]=(a+b) mod 16, [7:4] must be 0
- busy  output  1  high while a sweep is in progress
- done  output  1  level; high from sweep completion until the next accepted start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  9  number of mismatching pairs, 0..256
- first_fail  output  8  op byte of the first mismatch; 0 if none
- first_fail_valid  output  1  at least one mismatch has been recorded

Behaviour:
- Reset (synchronous, on a clk edge with reset=1) overrides everything, including a sweep in progress:
  - state IDLE; op_out, err_count, first_fail, idx and hold counter all 0.
  - busy, done, pass and first_fail_valid all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 → RUN:
  - idx=0, op_out=0x00, err_count=0, first_fail=0, first_fail_valid=0, done=0, pass=0, hold counter=0.
- start is ignored while in RUN.
- RUN per pair:
  - op_out=idx, held for exactly LATENCY+1 cycles.
  - The hold counter counts 0..LATENCY. On the edge where the counter equals LATENCY, sum_in is sampled and compared with expected = {4'b0000, (idx[7:4]+idx[3:0])[3:0]}. The carry is dropped and all 8 bits are compared.
  - On mismatch: err_count+1. If first_fail_valid=0, then first_fail=idx and first_fail_valid=1.
  - On that same edge: if idx<255, idx+1, op_out=idx+1 and counter=0; if idx==255, go to DONE.
- DONE:
  - busy=0, done=1, pass=(err_count==0). op_out holds 0xFF. Results hold until the next start.
- busy=1 exactly while in RUN.
- A full sweep lasts 256*(LATENCY+1) cycles. done rises on the edge that samples pair 255.
- Arithmetic:
  - idx is an 8-bit counter and never wraps within a sweep.
  - err_count cannot overflow: maximum 256 fits in 9 bits.
- Simultaneous reset and start: reset wins.
- start arriving on the same edge as DONE entry is ignored, because the block is still in RUN on that edge.

Test Plan:
- Correct adder model (registered, 1-cycle), LATENCY=1, pulse start → busy for 512 cycles; done=1, pass=1, err_count=0, first_fail_valid=0.
- Faulty model with sum_in = {4'b0, a|b} → err_count=175 (pairs with a&b≠0), first_fail=0x11, pass=0.
- Model forcing sum_in[7:4]=4'h1, otherwise correct → err_count=256, first_fail=0x00, first_fail_valid=1.
- Correct adder delayed by 2 registers while LATENCY=1 → err_count=255, first_fail=0x01 (each sample sees the previous pair). Rerun with LATENCY=2 → pass=1 after 768 cycles.
- Reset asserted for 1 cycle at pair 100 → next cycle: all outputs 0, state IDLE. A new start then completes a clean sweep with pass=1.
- start pulsed mid-RUN → ignored, with no restart and an unchanged cycle count. start pulsed in DONE → err_count and done clear and a new sweep begins, op_out=0x00.

Source files
------------

// File: rtl/adder_sweep_checker.sv
// Stimulus/check side of the nibble-adder loopback: sweeps all 256 {a,b} operand pairs,
// compares the returned sum and reports error count, first failing pair and pass.
module adder_sweep_checker #(
   parameter int unsigned LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] op_out,
   input  logic [7:0] sum_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] err_count,
   output logic [7:0] first_fail,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [3:0] HoldMax = 4'(LATENCY);

   state_e     state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [8:0] err_q, err_d;
   logic [7:0] ff_q, ff_d;
   logic       ffv_q, ffv_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;

   logic [3:0] sum4;
   logic [7:0] expected;
   logic       mismatch;

   // Carry is dropped; the upper nibble must come back as zero.
   assign sum4     = idx_q[7:4] + idx_q[3:0];
   assign expected = {4'b0000, sum4};
   assign mismatch = (sum_in != expected);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               idx_d   = 8'h00;
               cnt_d   = 4'd0;
               err_d   = 9'd0;
               ff_d    = 8'h00;
               ffv_d   = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         StRun: begin
            if (cnt_q == HoldMax) begin
               if (mismatch) begin
                  err_d = err_q + 9'd1;
                  if (!ffv_q) begin
                     ff_d  = idx_q;
                     ffv_d = 1'b1;
                  end
               end
               if (idx_q == 8'hFF) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 9'd0);
               end else begin
                  idx_d = idx_q + 8'd1;
                  cnt_d = 4'd0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= 8'h00;
         cnt_q   <= 4'd0;
         err_q   <= 9'd0;
         ff_q    <= 8'h00;
         ffv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign op_out           = idx_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: behavioural adder models in loopback, a cycle-level
// reference model of the sweep, and directed scenarios with literal expectations.
module tb_adder_sweep_checker;

   localparam int L1 = 1;

   logic       clk = 1'b0;
   logic       reset, start1, start2;
   logic [7:0] op1, sum1, op2, sum2;
   logic       busy1, done1, pass1, ffv1;
   logic       busy2, done2, pass2, ffv2;
   logic [8:0] err1, err2;
   logic [7:0] ff1, ff2;
   int         mode;
   int         total = 0;
   int         bad = 0;
   bit         chk_en = 1'b0;

   always #5 clk = ~clk;

   adder_sweep_checker #(.LATENCY(L1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .op_out(op1), .sum_in(sum1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail(ff1), .first_fail_valid(ffv1)
   );

   adder_sweep_checker #(.LATENCY(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .op_out(op2), .sum_in(sum2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail(ff2), .first_fail_valid(ffv2)
   );

   // Adder variants: 0 correct, 1 a|b, 2 upper nibble forced to 1, 3 correct but 2 regs deep.
   function automatic logic [7:0] adder_fn(input int md, input logic [7:0] op);
      logic [3:0] a, b, s;
      a = op[7:4];
      b = op[3:0];
      s = a + b;
      case (md)
         1:       return {4'b0000, a | b};
         2:       return {4'h1, s};
         default: return {4'b0000, s};
      endcase
   endfunction

   logic [7:0] r1, r2, d1, d2;
   always @(posedge clk) begin
      r1 <= adder_fn((mode == 3) ? 0 : mode, op1);
      r2 <= r1;
      d1 <= adder_fn(0, op2);
      d2 <= d1;
   end
   assign sum1 = (mode == 3) ? r2 : r1;
   assign sum2 = d2;

   // Does pair p mismatch under adder variant md, given the operand shown before the sweep?
   function automatic bit pair_bad(input int md, input int p, input logic [7:0] prev);
      logic [7:0] seen, got;
      int         want, gv;
      seen = (md == 3) ? ((p == 0) ? prev : 8'(p - 1)) : 8'(p);
      got  = adder_fn((md == 3) ? 0 : md, seen);
      want = ((p / 16) + (p % 16)) % 16;
      gv   = int'(got);
      return gv != want;
   endfunction

   // Reference model: counts cycles since an accepted start; pair p is judged every L1+1 cycles.
   bit         m_run, m_done, m_ffv;
   int         m_cyc, m_err;
   logic [7:0] m_ff, m_op;
   bit         bad_tab [256];

   always @(posedge clk) begin
      if (reset) begin
         m_run = 0; m_done = 0; m_cyc = 0; m_err = 0; m_ff = 0; m_ffv = 0; m_op = 0;
      end else if (!m_run && start1) begin
         for (int p = 0; p < 256; p++) bad_tab[p] = pair_bad(mode, p, m_op);
         m_run = 1; m_done = 0; m_cyc = 0; m_err = 0; m_ff = 0; m_ffv = 0; m_op = 0;
      end else if (m_run) begin
         m_cyc++;
         if (m_cyc % (L1 + 1) == 0) begin
            int p;
            p = m_cyc / (L1 + 1) - 1;
            if (bad_tab[p]) begin
               m_err++;
               if (!m_ffv) begin
                  m_ff  = 8'(p);
                  m_ffv = 1;
               end
            end
            if (p == 255) begin
               m_run  = 0;
               m_done = 1;
            end else begin
               m_op = 8'(p + 1);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 32'(busy1), 32'(m_run));
         check("cyc_done", 32'(done1), 32'(m_done));
         check("cyc_op", 32'(op1), 32'(m_op));
         check("cyc_err", 32'(err1), 32'(m_err));
         check("cyc_ff", 32'(ff1), 32'(m_ff));
         check("cyc_ffv", 32'(ffv1), 32'(m_ffv));
         check("cyc_pass", 32'(pass1), 32'(m_done && m_err == 0));
      end
   end

   task automatic run_sweep(input int md, input int mid_start, input bit edge_start,
                            output int nbusy);
      mode = md;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("start_op", 32'(op1), 32'h0);
      check("start_busy", 32'(busy1), 32'h1);
      nbusy = 0;
      for (int i = 0; i < 5000; i++) begin
         if (!busy1) break;
         nbusy++;
         start1 = (nbusy == mid_start) || (edge_start && nbusy == 512);
         @(negedge clk);
      end
      start1 = 1'b0;
   endtask

   int  n;
   bit  hit;

   initial begin
      reset = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
      repeat (3) @(negedge clk);
      check("rst_op", 32'(op1), 32'h0);
      check("rst_busy", 32'(busy1), 32'h0);
      check("rst_done", 32'(done1), 32'h0);
      check("rst_err", 32'(err1), 32'h0);
      check("rst_ffv", 32'(ffv1), 32'h0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Correct adder; a start mid-run and one on the DONE-entry edge are both ignored.
      run_sweep(0, 300, 1'b1, n);
      check("m0_cycles", 32'(n), 32'd512);
      check("m0_done", 32'(done1), 32'h1);
      check("m0_pass", 32'(pass1), 32'h1);
      check("m0_err", 32'(err1), 32'h0);
      check("m0_ffv", 32'(ffv1), 32'h0);
      check("m0_op", 32'(op1), 32'hFF);

      // a|b adder, started straight from DONE.
      run_sweep(1, 0, 1'b0, n);
      check("m1_err", 32'(err1), 32'd175);
      check("m1_ff", 32'(ff1), 32'h11);
      check("m1_pass", 32'(pass1), 32'h0);
      check("m1_model_err", 32'(m_err), 32'd175);

      run_sweep(2, 0, 1'b0, n);
      check("m2_err", 32'(err1), 32'd256);
      check("m2_ff", 32'(ff1), 32'h00);
      check("m2_ffv", 32'(ffv1), 32'h1);
      check("m2_model_err", 32'(m_err), 32'd256);

      // Two-register adder against LATENCY=1, from a freshly reset operand of 0.
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      run_sweep(3, 0, 1'b0, n);
      check("m3_err", 32'(err1), 32'd255);
      check("m3_ff", 32'(ff1), 32'h01);
      check("m3_model_ff", 32'(m_ff), 32'h01);

      // Reset in the middle of pair 100.
      mode = 0;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (op1 == 8'd100) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_mid_reached", 32'(hit), 32'h1);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("rstm_op", 32'(op1), 32'h0);
      check("rstm_busy", 32'(busy1), 32'h0);
      check("rstm_done", 32'(done1), 32'h0);
      check("rstm_pass", 32'(pass1), 32'h0);
      check("rstm_err", 32'(err1), 32'h0);
      check("rstm_ff", 32'(ff1), 32'h0);
      run_sweep(0, 0, 1'b0, n);
      check("post_rst_cycles", 32'(n), 32'd512);
      check("post_rst_pass", 32'(pass1), 32'h1);

      // LATENCY=2 instance with the two-register adder.
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         if (!busy2) break;
         n++;
         @(negedge clk);
      end
      check("l2_cycles", 32'(n), 32'd768);
      check("l2_done", 32'(done2), 32'h1);
      check("l2_pass", 32'(pass2), 32'h1);
      check("l2_err", 32'(err2), 32'h0);
      check("l2_ffv", 32'(ffv2), 32'h0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
